// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback-port arbiter and its aux result FIFO.
package wb_arb_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STALL = 2'd2
   } arb_state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
      return 32'd1 << rd;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of writeback requests; exposes per-entry valid and rd
// so the arbiter can build the pending-destination mask for the hazard unit.
module wb_fifo
   import wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  wb_req_t               push_req,
   input  logic                  pop,
   output wb_req_t               head,
   output logic                  full,
   output logic                  empty,
   output logic                  full_nxt,
   output logic                  empty_nxt,
   output logic [DEPTH-1:0]      entry_vld,
   output logic [DEPTH-1:0][4:0] entry_rd
);
   localparam int unsigned      PTR_W    = $clog2(DEPTH);
   localparam int unsigned      CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   wb_req_t          mem_q [DEPTH];
   wb_req_t          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (cnt_q == CNT_FULL);
   assign empty     = (cnt_q == CNT_ZERO);
   assign full_nxt  = (cnt_d == CNT_FULL);
   assign empty_nxt = (cnt_d == CNT_ZERO);
   assign head      = mem_q[rd_ptr_q];
   assign entry_vld = vld_q;
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // Per-entry destination view for the pending mask.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         entry_rd[i] = mem_q[i].rd;
      end
   end

   // Pointer, occupancy and storage next-state.
   always_comb begin
      mem_d    = mem_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_pop_s) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_req;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= CNT_ZERO;
         vld_q    <= {DEPTH{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by vld_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the W stage (priority) and queued aux results,
// with a starvation FSM requesting a one-bubble stall. Optional counters: WB_ARB_PERF_EN.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_vld,
   input  logic        pipe_wen,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        aux_valid,
   output logic        aux_ready,
   input  logic [4:0]  aux_rd,
   input  logic [31:0] aux_data,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req,
   output logic [31:0] aux_pending
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0] perf_conflict,
   output logic [31:0] perf_stall
`endif
);
   localparam int unsigned    AGE_W    = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
   localparam logic [AGE_W-1:0] AGE_TRIP = AGE_W'(STARVE_LIMIT - 1);
   localparam logic [AGE_W-1:0] AGE_ZERO = {AGE_W{1'b0}};

   arb_state_e              state_q, state_d;
   logic [AGE_W-1:0]        age_q, age_d;
   logic [AGE_W-1:0]        age_inc_s;
   logic                    aux_ready_q, aux_ready_d;
   logic                    pipe_act_s;
   logic                    aux_grant_s;
   logic                    push_s;
   logic                    pop_s;
   wb_req_t                 push_req_s;
   wb_req_t                 head_s;
   logic                    fifo_full_s, fifo_empty_s;
   logic                    fifo_full_nxt_s, fifo_empty_nxt_s;
   logic [DEPTH-1:0]        entry_vld_s;
   logic [DEPTH-1:0][4:0]   entry_rd_s;
   logic [31:0]             pending_s;

   assign pipe_act_s  = pipe_vld & pipe_wen & (pipe_rd != REG_X0);
   assign aux_grant_s = ~pipe_act_s & ~fifo_empty_s;
   assign pop_s       = aux_grant_s & ~rst;
   assign push_s      = aux_valid & aux_ready_q & ~fifo_full_s & ~rst;
   assign push_req_s  = '{rd: aux_rd, data: aux_data};
   assign aux_ready   = aux_ready_q;
   assign stall_req   = (state_q == STALL) & ~rst;
   assign age_inc_s   = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_req  (push_req_s),
      .pop       (pop_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .full_nxt  (fifo_full_nxt_s),
      .empty_nxt (fifo_empty_nxt_s),
      .entry_vld (entry_vld_s),
      .entry_rd  (entry_rd_s)
   );

   // Write-port mux: pipeline first, then FIFO head; an rd=x0 head drains silently.
   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = REG_X0;
      rf_wdata = 32'd0;
      if (rst) begin
         rf_wen = 1'b0;
      end else if (pipe_act_s) begin
         rf_wen   = 1'b1;
         rf_waddr = pipe_rd;
         rf_wdata = pipe_data;
      end else if (aux_grant_s) begin
         rf_wen   = (head_s.rd != REG_X0);
         rf_waddr = head_s.rd;
         rf_wdata = head_s.data;
      end else begin
         rf_wen = 1'b0;
      end
   end

   // Destinations still queued; x0 is never a hazard.
   always_comb begin
      pending_s = 32'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (entry_vld_s[i]) begin
            pending_s = pending_s | rd_onehot(entry_rd_s[i]);
         end else begin
            pending_s = pending_s;
         end
      end
      pending_s[0] = 1'b0;
      aux_pending  = rst ? 32'd0 : pending_s;
   end

   // Starvation FSM; IDLE also ages a freshly pushed head so the stall lands on time.
   always_comb begin
      state_d     = state_q;
      age_d       = age_q;
      aux_ready_d = ~fifo_full_nxt_s;
      case (state_q)
         IDLE, WAIT: begin
            if (fifo_empty_s) begin
               state_d = IDLE;
               age_d   = AGE_ZERO;
            end else if (pop_s) begin
               age_d   = AGE_ZERO;
               state_d = fifo_empty_nxt_s ? IDLE : WAIT;
            end else begin
               age_d   = age_inc_s;
               state_d = (age_inc_s >= AGE_TRIP) ? STALL : WAIT;
            end
         end
         STALL: begin
            if (pop_s) begin
               age_d   = AGE_ZERO;
               state_d = fifo_empty_nxt_s ? IDLE : WAIT;
            end else if (fifo_empty_s) begin
               age_d   = AGE_ZERO;
               state_d = IDLE;
            end else begin
               age_d   = age_inc_s;
               state_d = STALL;
            end
         end
         default: begin
            state_d = IDLE;
            age_d   = AGE_ZERO;
         end
      endcase
   end

   // FSM, age and ready registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         age_q       <= AGE_ZERO;
         aux_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         age_q       <= age_d;
         aux_ready_q <= aux_ready_d;
      end
   end

`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_conflict_q, perf_conflict_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Free-running event counters, wrapping naturally.
   always_comb begin
      perf_conflict_d = perf_conflict_q;
      perf_stall_d    = perf_stall_q;
      if (pipe_act_s & ~fifo_empty_s) begin
         perf_conflict_d = perf_conflict_q + 32'd1;
      end else begin
         perf_conflict_d = perf_conflict_q;
      end
      if (stall_req) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end else begin
         perf_stall_d = perf_stall_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_conflict_q <= 32'd0;
         perf_stall_q    <= 32'd0;
      end else begin
         perf_conflict_q <= perf_conflict_d;
         perf_stall_q    <= perf_stall_d;
      end
   end

   assign perf_conflict = perf_conflict_q;
   assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_vld, pipe_wen;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        aux_valid, aux_ready;
   logic [4:0]  aux_rd;
   logic [31:0] aux_data;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
   logic [31:0] aux_pending;
`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_conflict, perf_stall;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_vld    (pipe_vld),
      .pipe_wen    (pipe_wen),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .aux_valid   (aux_valid),
      .aux_ready   (aux_ready),
      .aux_rd      (aux_rd),
      .aux_data    (aux_data),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .stall_req   (stall_req),
      .aux_pending (aux_pending)
`ifdef WB_ARB_PERF_EN
      ,
      .perf_conflict (perf_conflict),
      .perf_stall    (perf_stall)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pipe_vld = 1'b0; pipe_wen = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
      aux_valid = 1'b0; aux_rd = 5'd0; aux_data = 32'd0;
      tick; tick;
      #1;
      chk("rst_rf_wen",    32'(rf_wen),      32'd0);
      chk("rst_stall",     32'(stall_req),   32'd0);
      chk("rst_pending",   aux_pending,      32'd0);
      chk("rst_ready",     32'(aux_ready),   32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready_lag", 32'(aux_ready),   32'd0);
      tick; #1;
      chk("post_rst_ready", 32'(aux_ready),  32'd1);

      // Single aux result on an idle pipe
      aux_valid = 1'b1; aux_rd = 5'd5; aux_data = 32'hDEAD_BEEF;
      #1;
      chk("t1_no_bypass", 32'(rf_wen), 32'd0);
      tick; aux_valid = 1'b0; #1;
      chk("t1_wen",     32'(rf_wen),   32'd1);
      chk("t1_waddr",   32'(rf_waddr), 32'd5);
      chk("t1_wdata",   rf_wdata,      32'hDEAD_BEEF);
      chk("t1_pending", aux_pending,   32'h0000_0020);
      tick; #1;
      chk("t1_pending_clr", aux_pending,  32'd0);
      chk("t1_wen_clr",     32'(rf_wen),  32'd0);

      // rd=x0 head drains silently, next entry follows
      aux_valid = 1'b1; aux_rd = 5'd0; aux_data = 32'h0000_1234;
      tick; aux_rd = 5'd7; aux_data = 32'h0000_0077; #1;
      chk("t4_x0_wen",     32'(rf_wen), 32'd0);
      chk("t4_x0_pending", aux_pending, 32'd0);
      tick; aux_valid = 1'b0; #1;
      chk("t4_next_wen",   32'(rf_wen),   32'd1);
      chk("t4_next_waddr", 32'(rf_waddr), 32'd7);
      chk("t4_next_pend",  aux_pending,   32'h0000_0080);
      tick; #1;
      chk("t4_empty_wen",  32'(rf_wen), 32'd0);
      chk("t4_empty_pend", aux_pending, 32'd0);

      // Fill FIFO under continuous pipeline writes
      pipe_vld = 1'b1; pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h3333_0000;
      for (int i = 0; i < 4; i++) begin
         aux_valid = 1'b1; aux_rd = 5'(10 + i); aux_data = 32'h0000_00A0 + 32'(i);
         #1;
         chk("t2_ready",      32'(aux_ready), 32'd1);
         chk("t2_pipe_waddr", 32'(rf_waddr),  32'd3);
         tick;
      end
      aux_rd = 5'd9; aux_data = 32'h0000_0099;
      #1;
      chk("t2_full_ready", 32'(aux_ready), 32'd0);
      chk("t2_pending",    aux_pending,    32'h0000_3C00);
      chk("t2_pipe_data",  rf_wdata,       32'h3333_0000);
      tick; pipe_vld = 1'b0; #1;
      chk("t2_full_pop_ready", 32'(aux_ready), 32'd0);
      chk("t2_drain_wen",      32'(rf_wen),    32'd1);
      chk("t2_drain0_waddr",   32'(rf_waddr),  32'd10);
      chk("t2_drain0_wdata",   rf_wdata,       32'h0000_00A0);
      tick; aux_valid = 1'b0; #1;
      chk("t2_ready_back", 32'(aux_ready), 32'd1);
      chk("t2_pending_3",  aux_pending,    32'h0000_3800);
      for (int j = 1; j < 4; j++) begin
         chk("t2_drain_waddr", 32'(rf_waddr), 32'(10 + j));
         chk("t2_drain_wdata", rf_wdata,      32'h0000_00A0 + 32'(j));
         tick; #1;
      end
      chk("t2_done_wen",  32'(rf_wen), 32'd0);
      chk("t2_done_pend", aux_pending, 32'd0);

      // Starvation: stall after 8 cycles, pipe wins once, then aux drains
      pipe_vld = 1'b1;
      aux_valid = 1'b1; aux_rd = 5'd20; aux_data = 32'hCAFE_0001;
      #1;
      chk("t3_stall_push", 32'(stall_req), 32'd0);
      tick; aux_valid = 1'b0;
      for (int k = 1; k < 8; k++) begin
         #1;
         chk("t3_no_stall", 32'(stall_req), 32'd0);
         tick;
      end
      #1;
      chk("t3_stall_rise", 32'(stall_req), 32'd1);
      chk("t3_pipe_wins",  32'(rf_waddr),  32'd3);
      tick; pipe_vld = 1'b0; #1;
      chk("t3_stall_hold", 32'(stall_req), 32'd1);
      chk("t3_aux_wen",    32'(rf_wen),    32'd1);
      chk("t3_aux_waddr",  32'(rf_waddr),  32'd20);
      chk("t3_aux_wdata",  rf_wdata,       32'hCAFE_0001);
      tick; #1;
      chk("t3_stall_fall", 32'(stall_req), 32'd0);
      chk("t3_idle_wen",   32'(rf_wen),    32'd0);

      // Reset with three queued entries
      pipe_vld = 1'b1;
      for (int m = 0; m < 3; m++) begin
         aux_valid = 1'b1; aux_rd = 5'(6 + m); aux_data = 32'(m);
         tick;
      end
      aux_valid = 1'b0;
      #1;
      chk("t5_pending_q", aux_pending, 32'h0000_01C0);
      rst = 1'b1; pipe_vld = 1'b0;
      #1;
      chk("t5_in_rst_wen",  32'(rf_wen), 32'd0);
      chk("t5_in_rst_pend", aux_pending, 32'd0);
      tick; rst = 1'b0; #1;
      chk("t5_after_wen",   32'(rf_wen),    32'd0);
      chk("t5_after_pend",  aux_pending,    32'd0);
      chk("t5_after_stall", 32'(stall_req), 32'd0);
      chk("t5_after_ready", 32'(aux_ready), 32'd0);
      tick; #1;
      chk("t5_ready_back",  32'(aux_ready), 32'd1);
      chk("t5_empty_wen",   32'(rf_wen),    32'd0);

`ifdef WB_ARB_PERF_EN
      chk("perf_clr_conflict", perf_conflict, 32'd0);
      chk("perf_clr_stall",    perf_stall,    32'd0);
      pipe_vld = 1'b1; aux_valid = 1'b1; aux_rd = 5'd21; aux_data = 32'h0000_0021;
      tick; aux_valid = 1'b0;
      for (int n = 0; n < 5; n++) tick;
      pipe_vld = 1'b0;
      tick; #1;
      chk("perf_conflict_5", perf_conflict, 32'd5);
      chk("perf_stall_0",    perf_stall,    32'd0);
      pipe_vld = 1'b1; aux_valid = 1'b1; aux_rd = 5'd22; aux_data = 32'h0000_0022;
      tick; aux_valid = 1'b0;
      for (int n = 0; n < 7; n++) tick;
      #1;
      chk("perf_stall_seen", 32'(stall_req), 32'd1);
      pipe_vld = 1'b0;
      tick; #1;
      chk("perf_conflict_12", perf_conflict, 32'd12);
      chk("perf_stall_1",     perf_stall,    32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
